// File: rtl/cim_xbar_responder_if.sv
// Host-side bus of the crossbar compute-in-memory responder: input/weight writes,
// MVM start, busy status and result readback.
interface cim_xbar_responder_if #(
    parameter int unsigned xbar_size     = 512,
    parameter int unsigned datatype_size = 8
);
    localparam int unsigned AddrW = $clog2(xbar_size);

    logic                     i_we;
    logic [AddrW-1:0]         i_wr_addr;
    logic [datatype_size-1:0] i_wr_data;
    logic                     i_w_we;
    logic [AddrW-1:0]         i_w_row;
    logic [xbar_size-1:0]     i_w_data;
    logic                     i_start;
    logic                     o_busy;
    logic [AddrW-1:0]         i_rd_addr;
    logic [datatype_size-1:0] o_rd_data;

    modport master (
        output i_we, i_wr_addr, i_wr_data, i_w_we, i_w_row, i_w_data, i_start, i_rd_addr,
        input  o_busy, o_rd_data
    );

    modport slave (
        input  i_we, i_wr_addr, i_wr_data, i_w_we, i_w_row, i_w_data, i_start, i_rd_addr,
        output o_busy, o_rd_data
    );
endinterface

// File: rtl/cim_xbar_responder.sv
// Binary-weight crossbar MVM: one input row per cycle is added into all column
// accumulators in parallel, then results are saturated into a readable buffer.
module cim_xbar_responder #(
    parameter int unsigned xbar_size     = 512,
    parameter int unsigned datatype_size = 8
) (
    input logic                   clk,
    input logic                   rst,
    cim_xbar_responder_if.slave   bus
);
    localparam int unsigned AddrW = $clog2(xbar_size);
    localparam int unsigned AccW  = datatype_size + AddrW;
    localparam logic [AccW-1:0] SatMax = {{AddrW{1'b0}}, {datatype_size{1'b1}}};
    localparam logic [AddrW-1:0] LastRow = AddrW'(xbar_size - 1);

    typedef enum logic [1:0] {StIdle, StCompute, StLatch} state_e;

    state_e                   state_q, state_d;
    logic                     busy_q, busy_d;
    logic [AddrW-1:0]         row_q, row_d;
    logic [datatype_size-1:0] rd_data_q, rd_data_d;

    logic [datatype_size-1:0] in_buf_q [xbar_size];
    logic [datatype_size-1:0] in_buf_d [xbar_size];
    logic [xbar_size-1:0]     w_q      [xbar_size];
    logic [xbar_size-1:0]     w_d      [xbar_size];
    logic [AccW-1:0]          acc_q    [xbar_size];
    logic [AccW-1:0]          acc_d    [xbar_size];
    logic [datatype_size-1:0] res_q    [xbar_size];
    logic [datatype_size-1:0] res_d    [xbar_size];

    logic wr_en, acc_clr, acc_en, res_load;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (bus.i_start) state_d = StCompute;
            StCompute: if (row_q == LastRow) state_d = StLatch;
            StLatch:   state_d = StIdle;
            default:   state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    // FSM: datapath strobes
    always_comb begin
        wr_en    = 1'b0;
        acc_clr  = 1'b0;
        acc_en   = 1'b0;
        res_load = 1'b0;
        unique case (state_q)
            StIdle: begin
                wr_en   = 1'b1;
                acc_clr = bus.i_start;
            end
            StCompute: acc_en   = 1'b1;
            StLatch:   res_load = 1'b1;
            default: ;
        endcase
    end

    // Host writes land at the same edge as start, so the MVM sees them.
    always_comb begin
        in_buf_d = in_buf_q;
        w_d      = w_q;
        if (wr_en && bus.i_we) in_buf_d[bus.i_wr_addr] = bus.i_wr_data;
        if (wr_en && bus.i_w_we) w_d[bus.i_w_row] = bus.i_w_data;
    end

    always_comb begin
        row_d = row_q;
        if (acc_clr) begin
            row_d = '0;
        end else if (acc_en) begin
            row_d = row_q + AddrW'(1);
        end
        for (int unsigned j = 0; j < xbar_size; j++) begin
            acc_d[j] = acc_q[j];
            if (acc_clr) begin
                acc_d[j] = '0;
            end else if (acc_en && w_q[row_q][j]) begin
                acc_d[j] = acc_q[j] + AccW'(in_buf_q[row_q]);
            end
            res_d[j] = res_q[j];
            if (res_load) begin
                res_d[j] = (acc_q[j] > SatMax) ? {datatype_size{1'b1}}
                                               : acc_q[j][datatype_size-1:0];
            end
        end
        rd_data_d = res_q[bus.i_rd_addr];
    end

    // Input vector and weights are deliberately not reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_buf_q <= in_buf_d;
            w_q      <= w_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            row_q     <= '0;
            acc_q     <= '{default: '0};
            res_q     <= '{default: '0};
            rd_data_q <= '0;
        end else begin
            row_q     <= row_d;
            acc_q     <= acc_d;
            res_q     <= res_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign bus.o_busy    = busy_q;
    assign bus.o_rd_data = rd_data_q;

endmodule

// File: tb/tb_cim_xbar_responder.sv
// Scoreboard bench: a behavioural model predicts busy and read data per cycle;
// a monitor on the falling edge compares the DUT against the predictions.
module tb_cim_xbar_responder;
    localparam int unsigned N  = 4;
    localparam int unsigned D  = 8;
    localparam int unsigned AW = $clog2(N);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cim_xbar_responder_if #(.xbar_size(N), .datatype_size(D)) bus ();

    cim_xbar_responder #(.xbar_size(N), .datatype_size(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    logic [D-1:0]  in_m   [N];
    logic [N-1:0]  w_m    [N];
    int            res_m  [N];
    int            pend_m [N];
    int            busy_left = 0;
    int            rd_q [$];
    logic          rd_req  = 1'b0;
    logic          rd_pend = 1'b0;
    logic          mon_en  = 1'b0;

    function automatic void mvm();
        for (int j = 0; j < int'(N); j++) begin
            int sum = 0;
            for (int r = 0; r < int'(N); r++) if (w_m[r][j]) sum += int'(in_m[r]);
            pend_m[j] = (sum > 255) ? 255 : sum;
        end
    endfunction

    // Reference model, evaluated at each rising edge on the inputs being sampled.
    initial begin
        for (int j = 0; j < int'(N); j++) res_m[j] = 0;
        forever begin
            @(posedge clk);
            if (rd_req) rd_q.push_back(rst ? res_m[bus.i_rd_addr] : 0);
            rd_pend = rd_req;
            if (!rst) begin
                busy_left = 0;
                for (int j = 0; j < int'(N); j++) res_m[j] = 0;
            end else if (busy_left != 0) begin
                busy_left--;
                if (busy_left == 0) res_m = pend_m;
            end else begin
                if (bus.i_we) in_m[bus.i_wr_addr] = bus.i_wr_data;
                if (bus.i_w_we) w_m[bus.i_w_row] = bus.i_w_data;
                if (bus.i_start) begin
                    mvm();
                    busy_left = N + 1;
                end
            end
        end
    end

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                n_checks++;
                if (bus.o_busy !== (busy_left != 0)) begin
                    n_fail++;
                    $display("FAIL busy @%0t: got %0b expected %0b", $time, bus.o_busy,
                             busy_left != 0);
                end
                if (rd_pend) begin
                    n_checks++;
                    if (rd_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL rd_queue @%0t: read data with no prediction", $time);
                    end else begin
                        int exp_v;
                        exp_v = rd_q.pop_front();
                        if (int'(bus.o_rd_data) != exp_v) begin
                            n_fail++;
                            $display("FAIL rd_data @%0t: got %0d expected %0d", $time,
                                     bus.o_rd_data, exp_v);
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bus.i_we    = 1'b0;
        bus.i_w_we  = 1'b0;
        bus.i_start = 1'b0;
        rd_req      = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr_in(input int a, input int d);
        bus.i_we      = 1'b1;
        bus.i_wr_addr = AW'(a);
        bus.i_wr_data = D'(d);
        tick();
    endtask

    task automatic wr_w(input int r, input logic [N-1:0] d);
        bus.i_w_we  = 1'b1;
        bus.i_w_row = AW'(r);
        bus.i_w_data = d;
        tick();
    endtask

    task automatic start();
        bus.i_start = 1'b1;
        tick();
    endtask

    task automatic rd_all();
        for (int a = 0; a < int'(N); a++) begin
            rd_req        = 1'b1;
            bus.i_rd_addr = AW'(a);
            tick();
        end
    endtask

    task automatic identity();
        for (int r = 0; r < int'(N); r++) wr_w(r, N'(1) << r);
    endtask

    initial begin
        int busy_cnt;
        bus.i_we = 1'b0; bus.i_wr_addr = '0; bus.i_wr_data = '0;
        bus.i_w_we = 1'b0; bus.i_w_row = '0; bus.i_w_data = '0;
        bus.i_start = 1'b0; bus.i_rd_addr = '0;

        // Reset held two cycles
        rst = 1'b0;
        tick();
        mon_en = 1'b1;
        tick();
        rst = 1'b1;
        rd_all();

        // Identity weights
        identity();
        wr_in(0, 3); wr_in(1, 5); wr_in(2, 7); wr_in(3, 9);
        start();
        busy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.o_busy) busy_cnt++;
            tick();
        end
        n_checks++;
        if (busy_cnt != int'(N) + 1) begin
            n_fail++;
            $display("FAIL busy_len: got %0d expected %0d", busy_cnt, N + 1);
        end
        rd_all();

        // Saturation and plain sums with all-ones weights
        for (int r = 0; r < int'(N); r++) wr_w(r, '1);
        for (int a = 0; a < int'(N); a++) wr_in(a, 100);
        start(); idle(6); rd_all();
        for (int a = 0; a < int'(N); a++) wr_in(a, 10 * (a + 1));
        start(); idle(6); rd_all();

        // Activity while busy: start, write and reads all during the MVM
        wr_in(0, 11);
        start();
        bus.i_start = 1'b1; tick();
        wr_in(0, 77);
        rd_all();
        idle(4);
        rd_all();
        identity();
        start(); idle(6); rd_all();

        // Reset in the middle of COMPUTE at r=2
        start(); tick(); tick();
        rst = 1'b0;
        bus.i_we = 1'b1; bus.i_wr_addr = '0; bus.i_wr_data = 8'd200;
        bus.i_start = 1'b1;
        tick();
        rst = 1'b1;
        rd_all();
        start(); idle(6); rd_all();

        // Write in the same cycle as start
        bus.i_we = 1'b1; bus.i_wr_addr = '0; bus.i_wr_data = 8'd50;
        start(); idle(6); rd_all();

        // Randomized traffic, including back-to-back starts and sporadic resets
        for (int i = 0; i < 600; i++) begin
            bus.i_we      = ($urandom % 3) == 0;
            bus.i_wr_addr = AW'($urandom);
            bus.i_wr_data = D'($urandom);
            bus.i_w_we    = ($urandom % 4) == 0;
            bus.i_w_row   = AW'($urandom);
            bus.i_w_data  = N'($urandom);
            bus.i_start   = ($urandom % 3) == 0;
            rd_req        = 1'b1;
            bus.i_rd_addr = AW'($urandom);
            rst           = ($urandom % 60) != 0;
            tick();
        end
        rst = 1'b1;
        idle(8);
        rd_all();
        idle(2);

        n_checks++;
        if (rd_q.size() != 0) begin
            n_fail++;
            $display("FAIL rd_drain: got %0d pending expected 0", rd_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cim_xbar_responder.md
CIM_XBAR_RESPONDER -- requirements
Module: cim_xbar_responder

Interface
REQ-001 Parameter xbar_size, default 512: crossbar rows = columns; SHALL be a power of two >= 2.
REQ-002 Parameter datatype_size, default 8: unsigned input-element and result width.
REQ-003 Port clk  input  1  sole clock, all logic on the rising edge.
REQ-004 Port rst  input  1  synchronous reset, active-low (rst==0 resets).
REQ-005 Port i_we  input  1  input-vector write enable.
REQ-006 Port i_wr_addr  input  $clog2(xbar_size)  input-vector row index.
REQ-007 Port i_wr_data  input  datatype_size  input-vector element.
REQ-008 Port i_w_we  input  1  weight-row write enable.
REQ-009 Port i_w_row  input  $clog2(xbar_size)  weight row index.
REQ-010 Port i_w_data  input  xbar_size  1-bit cell per column for that row.
REQ-011 Port i_start  input  1  one-cycle MVM start request.
REQ-012 Port o_busy  output  1  registered; high while an MVM is in progress.
REQ-013 Port i_rd_addr  input  $clog2(xbar_size)  result column index.
REQ-014 Port o_rd_data  output  datatype_size  registered result read data.

Function
REQ-015 State machine SHALL have states IDLE, COMPUTE, LATCH; o_busy SHALL be high exactly when state != IDLE.
REQ-016 In IDLE, i_we=1 SHALL write in_buf[i_wr_addr]=i_wr_data, and i_w_we=1 SHALL write w[i_w_row][*]=i_w_data.
REQ-017 In IDLE, i_start=1 SHALL clear all column accumulators, set row counter r=0, and enter COMPUTE.
REQ-018 Writes in the same IDLE cycle as i_start SHALL complete and SHALL be used by that MVM.
REQ-019 Each COMPUTE cycle SHALL add in_buf[r] to acc[j] for every column j where w[r][j]=1, all columns in parallel, then increment r.
REQ-020 After the cycle with r=xbar_size-1, the FSM SHALL enter LATCH.
REQ-021 Accumulator width SHALL be datatype_size+$clog2(xbar_size), unsigned, with no overflow.
REQ-022 LATCH SHALL copy res_buf[j]=min(acc[j], 2^datatype_size-1) (saturation) for all j, then enter IDLE.
REQ-023 o_busy SHALL rise the cycle after i_start is sampled and stay high for exactly xbar_size+1 cycles.
REQ-024 i_start, i_we and i_w_we SHALL be ignored while o_busy=1; in_buf and weights stay frozen.
REQ-025 o_rd_data SHALL equal res_buf[i_rd_addr] one cycle after i_rd_addr is sampled, in every state.
REQ-026 During COMPUTE, reads SHALL return the previous MVM's results; res_buf changes only in LATCH.
REQ-027 Back-to-back: i_start in the first IDLE cycle after LATCH SHALL be accepted with no bubble.

Reset
REQ-028 rst=0 SHALL force state=IDLE, o_busy=0, r=0, all acc=0, all res_buf=0 and o_rd_data=0 at the next edge.
REQ-029 rst=0 mid-COMPUTE SHALL abort the MVM; res_buf SHALL read 0, never partial sums.
REQ-030 in_buf and the weight array SHALL be unaffected by reset.
REQ-031 Writes and start SHALL be ignored in any cycle where rst=0.

Verification (xbar_size=4, datatype_size=8)
REQ-032 Reset: hold rst=0 two cycles, release -> o_busy=0; reads of addresses 0..3 return 0.
REQ-033 Identity weights (w[r][r]=1, all others 0), in_buf=[3,5,7,9], pulse i_start -> o_busy high exactly 5 cycles; reads of columns 0..3 return 3,5,7,9.
REQ-034 Saturation: all weights 1, in_buf=[100,100,100,100] -> every column reads 255; with in_buf=[10,20,30,40] every column reads 100.
REQ-035 While busy: i_start, i_we to row 0 with 77, and reads -> start ignored, in_buf[0] unchanged, reads return the previous results until LATCH.
REQ-036 Reset mid-MVM: assert rst=0 when r=2 -> next cycle o_busy=0 and all reads 0; a new i_start completes normally.
REQ-037 Same-cycle write+start: i_we(addr 0, 50) with i_start, identity weights -> column 0 reads 50.
